mtr_pwm_meas: RTL and testbench
===============================

Name: mtr_pwm_meas

Overview:
Receive-side counterpart of the motor driver. It watches the four H-bridge PWM lines (forward/reverse, left/right) and recovers each wheel's 11-bit speed and direction, once per 2048-clock window. It is used as an on-chip self-check of the drive path and as the measurement model in the system bench. It also flags illegal activity: shoot-through (forward and reverse high together) and a direction change inside one window.

Parameters:
PWM_W, 11, PWM counter width; window length = 2**PWM_W clocks; speed output width.

Ports:
clk  in  1  system clock; one clock; reset is synchronous and active-high
rst  in  1  synchronous active-high reset
PWM_frwrd_lft  in  1  left forward PWM, synchronous to clk
PWM_rev_lft  in  1  left reverse PWM
PWM_frwrd_rght  in  1  right forward PWM
PWM_rev_rght  in  1  right reverse PWM
lft_spd  out  PWM_W  measured left duty (high cycles per window)
lft_rev  out  1  measured left direction, 1 = reverse
rght_spd  out  PWM_W  measured right duty
rght_rev  out  1  measured right direction
meas_vld  out  1  one-cycle pulse when all outputs update
shoot_thru_lft  out  1  left fwd and rev were high in the same cycle during the last window
shoot_thru_rght  out  1  same, right channel
dir_chg_lft  out  1  both left lines had high cycles during the last window
dir_chg_rght  out  1  same, right channel

Behaviour:
- Reset: all outputs 0; the window counter and all accumulators are 0.
- Window counter win_cnt is PWM_W bits, free-running, 0..2**PWM_W-1, wraps to 0.
  - It is not aligned to the driver's PWM phase.
  - Any full window of a periodic PWM of the same period contains exactly duty high cycles, so no alignment is needed.
- Per channel, each cycle:
  - hi_f increments when the forward line is 1; hi_r increments when the reverse line is 1. Both are PWM_W+1 bits.
  - st (sticky) is set when both lines are 1.
- The sample taken in the cycle where win_cnt == max is included in the window. On the next clock edge:
  - Outputs are registered from the completed accumulators.
  - meas_vld = 1 for exactly one cycle.
  - Accumulators and st clear. The new window's first sample (win_cnt == 0) is accumulated into the cleared values in that same edge.
- Decode rules per channel, applied at window end (sat(x) = min(x, 2**PWM_W-1)):
  - hi_r == 0: rev = 0, spd = sat(hi_f).
  - hi_f == 0, hi_r != 0: rev = 1, spd = sat(hi_r).
  - Both nonzero: rev = (hi_r > hi_f), spd = sat(max(hi_f, hi_r)), dir_chg = 1. On a tie, rev = 0.
  - Both zero: spd = 0, rev = 0, dir_chg = 0.
  - shoot_thru = st. Shoot-through cycles count in both hi_f and hi_r.
- Outputs hold their values between meas_vld pulses.
- Latency: first meas_vld occurs 2**PWM_W cycles after the first cycle with rst low, then every 2**PWM_W cycles.
- Constant-high input yields 2**PWM_W high cycles, which saturates to 2047.
- Reset mid-window: the partial window is discarded, outputs return to 0, and timing restarts as above.

Decomposition:
- Package mtr_pkg:
  - PWM_W = 11 and PWM_PERIOD = 2048.
  - typedef spd_t, an 11-bit logic vector.
  - typedef chan_meas_t, a packed struct {spd, rev, shoot_thru, dir_chg}.
- Sub-module mtr_pwm_chan:
  - Holds one channel's accumulators, sticky flags and decode.
  - Inputs: clk, rst, frwrd, rev, win_end. Output: chan_meas_t.
  - Instantiated twice (left, right).
- Top level holds win_cnt, generates win_end (win_cnt == max), and registers meas_vld.

Test Plan:
- Drive PWM_frwrd_lft from a reference PWM11 with duty 1024 at an arbitrary phase, lft_rev = 0 -> each meas_vld after the first full window: lft_spd = 1024, lft_rev = 0, flags = 0.
- Right reverse, duty 100 -> rght_spd = 100, rght_rev = 1; left lines idle -> lft_spd = 0, lft_rev = 0.
- PWM_frwrd_rght held at 1 -> rght_spd = 2047 (saturated), rght_rev = 0; duty 0 on all lines -> all speeds 0.
- Left forward duty 600; switch to reverse duty 600 at win_cnt = 1500 -> that window: dir_chg_lft = 1, lft_rev = 0 (hi_f > hi_r), lft_spd = the max count. Next window: dir_chg_lft = 0, lft_rev = 1, lft_spd = 600.
- Force both left lines high for 3 cycles in one window -> shoot_thru_lft = 1 for that window only; cleared in the following window.
- Assert rst at win_cnt = 1000 for 2 cycles -> outputs 0 immediately after the reset edge; next meas_vld exactly 2048 cycles after the first cycle with rst low.

Source files
------------

// File: rtl/mtr_pwm_meas_pkg.sv
// mtr_pkg: shared types and helpers for the PWM measurement block.
//   PWM_W       PWM counter width; one window is 2**PWM_W clocks
//   spd_t       measured duty (high cycles per window, saturated)
//   cnt_t       raw per-window high-cycle count, one bit wider than spd_t
//   chan_meas_t one channel's decoded result {spd, rev, shoot_thru, dir_chg}
//   decode()    turns a channel's completed counts into chan_meas_t
package mtr_pkg;

    localparam int PWM_W      = 11;
    localparam int PWM_PERIOD = 2 ** PWM_W;

    typedef logic [PWM_W-1:0] spd_t;
    typedef logic [PWM_W:0]   cnt_t;

    typedef struct packed {
        spd_t spd;
        logic rev;
        logic shoot_thru;
        logic dir_chg;
    } chan_meas_t;

    // A line held high for a whole window counts 2**PWM_W, one past spd_t range.
    function automatic spd_t sat(input cnt_t x);
        return x[PWM_W] ? '1 : x[PWM_W-1:0];
    endfunction

    // rev = (hi_r > hi_f) covers every case at once: hi_r == 0 gives forward,
    // hi_f == 0 with hi_r != 0 gives reverse, a tie gives forward, both zero
    // gives forward with spd 0. The larger count always becomes the speed.
    function automatic chan_meas_t decode(input cnt_t hi_f, input cnt_t hi_r, input logic st);
        chan_meas_t m;
        m.rev        = (hi_r > hi_f);
        m.spd        = sat(m.rev ? hi_r : hi_f);
        m.dir_chg    = (|hi_f) & (|hi_r);
        m.shoot_thru = st;
        return m;
    endfunction

endpackage

// File: rtl/mtr_pwm_meas_if.sv
// mtr_pwm_meas_if: measurement result bundle of mtr_pwm_meas.
//   lft_spd/rght_spd   measured duty per wheel
//   lft_rev/rght_rev   measured direction, 1 = reverse
//   meas_vld           one-cycle pulse when every field updates
//   shoot_thru_*       fwd and rev high in the same cycle during the last window
//   dir_chg_*          both lines of a wheel had high cycles during the last window
// master = producer (the measurement block), slave = consumer.
interface mtr_pwm_meas_if #(parameter int PWM_W = mtr_pkg::PWM_W);

    logic [PWM_W-1:0] lft_spd;
    logic             lft_rev;
    logic [PWM_W-1:0] rght_spd;
    logic             rght_rev;
    logic             meas_vld;
    logic             shoot_thru_lft;
    logic             shoot_thru_rght;
    logic             dir_chg_lft;
    logic             dir_chg_rght;

    modport master (
        output lft_spd, lft_rev, rght_spd, rght_rev, meas_vld,
               shoot_thru_lft, shoot_thru_rght, dir_chg_lft, dir_chg_rght
    );

    modport slave (
        input lft_spd, lft_rev, rght_spd, rght_rev, meas_vld,
              shoot_thru_lft, shoot_thru_rght, dir_chg_lft, dir_chg_rght
    );

endinterface

// File: rtl/mtr_pwm_meas_chan.sv
// mtr_pwm_chan: one wheel's high-cycle accumulators, shoot-through sticky
// flag and end-of-window decode.
//   clk, rst   clock, synchronous active-high reset
//   frwrd, rev the wheel's two PWM lines
//   win_end    high in the last cycle of a window
//   meas       decoded result, updated on the edge that closes a window
module mtr_pwm_chan
    import mtr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frwrd,
    input  logic       rev,
    input  logic       win_end,
    output chan_meas_t meas
);

    cnt_t hi_f, hi_r;
    cnt_t hi_f_nxt, hi_r_nxt;
    logic st, st_nxt;

    // Counts including this cycle's sample; the last cycle of a window is
    // decoded from these so it is not lost.
    always_comb begin
        hi_f_nxt = hi_f + cnt_t'(frwrd);
        hi_r_nxt = hi_r + cnt_t'(rev);
        st_nxt   = st | (frwrd & rev);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_f <= '0;
            hi_r <= '0;
            st   <= 1'b0;
            meas <= '0;
        end else if (win_end) begin
            meas <= decode(hi_f_nxt, hi_r_nxt, st_nxt);
            hi_f <= '0;
            hi_r <= '0;
            st   <= 1'b0;
        end else begin
            hi_f <= hi_f_nxt;
            hi_r <= hi_r_nxt;
            st   <= st_nxt;
        end
    end

endmodule

// File: rtl/mtr_pwm_meas.sv
// mtr_pwm_meas: recovers each wheel's speed and direction from the four
// H-bridge PWM lines once per 2**PWM_W-clock window, and flags shoot-through
// and in-window direction changes.
//   clk, rst          clock, synchronous active-high reset
//   PWM_frwrd_lft     left forward PWM
//   PWM_rev_lft       left reverse PWM
//   PWM_frwrd_rght    right forward PWM
//   PWM_rev_rght      right reverse PWM
//   meas              result bundle (mtr_pwm_meas_if master)
// The window is free-running and not phase-locked to the driver: any full
// window of a periodic PWM with the same period holds exactly duty high cycles.
module mtr_pwm_meas #(
    parameter int PWM_W = mtr_pkg::PWM_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PWM_frwrd_lft,
    input  logic            PWM_rev_lft,
    input  logic            PWM_frwrd_rght,
    input  logic            PWM_rev_rght,
    mtr_pwm_meas_if.master  meas
);
    import mtr_pkg::*;

    localparam int NUM_CHAN = 2;   // 0 = left, 1 = right

    logic [PWM_W-1:0]    win_cnt;
    logic                win_end;
    logic                meas_vld_q;
    logic [NUM_CHAN-1:0] frwrd_v, rev_v;
    chan_meas_t          chan_meas [NUM_CHAN];

    assign win_end = &win_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            meas_vld_q <= 1'b0;
        end else begin
            win_cnt    <= win_cnt + PWM_W'(1);
            meas_vld_q <= win_end;   // aligned with the channel outputs
        end
    end

    assign frwrd_v = {PWM_frwrd_rght, PWM_frwrd_lft};
    assign rev_v   = {PWM_rev_rght,   PWM_rev_lft};

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        mtr_pwm_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .frwrd   (frwrd_v[c]),
            .rev     (rev_v[c]),
            .win_end (win_end),
            .meas    (chan_meas[c])
        );
    end

    assign meas.lft_spd         = chan_meas[0].spd;
    assign meas.lft_rev         = chan_meas[0].rev;
    assign meas.shoot_thru_lft  = chan_meas[0].shoot_thru;
    assign meas.dir_chg_lft     = chan_meas[0].dir_chg;
    assign meas.rght_spd        = chan_meas[1].spd;
    assign meas.rght_rev        = chan_meas[1].rev;
    assign meas.shoot_thru_rght = chan_meas[1].shoot_thru;
    assign meas.dir_chg_rght    = chan_meas[1].dir_chg;
    assign meas.meas_vld        = meas_vld_q;

endmodule

// File: tb/tb_mtr_pwm_meas.sv
// tb_mtr_pwm_meas: directed bench for mtr_pwm_meas. Each window's expected
// result is queued when its stimulus starts and checked at the meas_vld pulse
// that closes it; meas_vld timing and output hold are checked every cycle.
module tb_mtr_pwm_meas;

    localparam int W   = 11;
    localparam int PER = 2048;

    typedef struct packed {
        logic [W-1:0] ls;
        logic         lr, lst, ldc;
        logic [W-1:0] rs;
        logic         rr, rst_f, rdc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght;

    mtr_pwm_meas_if #(.PWM_W(W)) mif ();

    mtr_pwm_meas #(.PWM_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .PWM_frwrd_lft  (PWM_frwrd_lft),
        .PWM_rev_lft    (PWM_rev_lft),
        .PWM_frwrd_rght (PWM_frwrd_rght),
        .PWM_rev_rght   (PWM_rev_rght),
        .meas           (mif)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   t;            // cycle index since the last reset release
    exp_t sb[$];
    exp_t last;         // most recently checked result; outputs must hold it

    function automatic exp_t mk(input int ls, input logic lr, input logic lst, input logic ldc,
                                input int rs, input logic rr, input logic rst_f, input logic rdc);
        exp_t e;
        e.ls = W'(ls); e.lr = lr; e.lst = lst; e.ldc = ldc;
        e.rs = W'(rs); e.rr = rr; e.rst_f = rst_f; e.rdc = rdc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".lft_spd"},         32'(mif.lft_spd),         32'(e.ls));
        chk({tag, ".lft_rev"},         32'(mif.lft_rev),         32'(e.lr));
        chk({tag, ".shoot_thru_lft"},  32'(mif.shoot_thru_lft),  32'(e.lst));
        chk({tag, ".dir_chg_lft"},     32'(mif.dir_chg_lft),     32'(e.ldc));
        chk({tag, ".rght_spd"},        32'(mif.rght_spd),        32'(e.rs));
        chk({tag, ".rght_rev"},        32'(mif.rght_rev),        32'(e.rr));
        chk({tag, ".shoot_thru_rght"}, 32'(mif.shoot_thru_rght), 32'(e.rst_f));
        chk({tag, ".dir_chg_rght"},    32'(mif.dir_chg_rght),    32'(e.rdc));
    endtask

    // Drive one cycle, let the DUT sample it, then look at the outputs
    // at the following falling edge.
    task automatic step(input logic fl, input logic rl, input logic fr, input logic rr);
        PWM_frwrd_lft  = fl;
        PWM_rev_lft    = rl;
        PWM_frwrd_rght = fr;
        PWM_rev_rght   = rr;
        @(posedge clk);
        @(negedge clk);
        t++;
        chk("meas_vld", 32'(mif.meas_vld), 32'((t % PER) == 0));
        if (mif.meas_vld === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                last = sb.pop_front();
                chk_outs("win", last);
            end
        end
        if ((t % PER) == PER / 2) chk_outs("hold", last);
    endtask

    initial begin
        logic fl, rl, fr, rr;
        rst = 1'b1;
        PWM_frwrd_lft = 1'b0; PWM_rev_lft = 1'b0;
        PWM_frwrd_rght = 1'b0; PWM_rev_rght = 1'b0;
        t = 0;
        last = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.meas_vld", 32'(mif.meas_vld), 32'd0);
        chk_outs("reset", '0);
        rst = 1'b0;

        // Windows 0..8: directed waveforms, expectation queued at window start.
        for (int w = 0; w < 9; w++) begin
            case (w)
                0, 1: sb.push_back(mk(1024, 0, 0, 0, 100, 1, 0, 0));
                2:    sb.push_back(mk(0,    0, 0, 0, 100, 1, 0, 0));
                3:    sb.push_back(mk(0,    0, 0, 0, 2047, 0, 0, 0));
                4:    sb.push_back(mk(0,    0, 0, 0, 0,   0, 0, 0));
                5:    sb.push_back(mk(400,  0, 0, 1, 0,   0, 0, 0));
                6:    sb.push_back(mk(600,  1, 0, 0, 0,   0, 0, 0));
                7:    sb.push_back(mk(200,  0, 1, 1, 300, 1, 0, 1));
                default: sb.push_back(mk(200, 0, 0, 0, 50, 0, 0, 1));
            endcase
            for (int p = 0; p < PER; p++) begin
                fl = 1'b0; rl = 1'b0; fr = 1'b0; rr = 1'b0;
                case (w)
                    0, 1: begin
                        fl = ((p + 37) % PER) < 1024;
                        rr = ((p + 500) % PER) < 100;
                    end
                    2: rr = ((p + 500) % PER) < 100;
                    3: fr = 1'b1;
                    4: ;
                    5: begin   // forward 600 switching to reverse 600 at win_cnt 1500
                        fl = (p < 1500)  && (((p + 948) % PER) < 600);
                        rl = (p >= 1500) && (((p + 948) % PER) < 600);
                    end
                    6: rl = ((p + 948) % PER) < 600;
                    7: begin   // 3 shoot-through cycles left; reverse dominates right
                        fl = p < 200;
                        rl = (p >= 100) && (p < 103);
                        fr = p < 100;
                        rr = (p >= 1000) && (p < 1300);
                    end
                    default: begin   // right tie -> forward
                        fl = p < 200;
                        fr = p < 50;
                        rr = (p >= 500) && (p < 550);
                    end
                endcase
                step(fl, rl, fr, rr);
            end
        end

        // Partial window discarded by a reset at win_cnt 1000.
        for (int p = 0; p < 1000; p++) step(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        PWM_frwrd_lft = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.meas_vld", 32'(mif.meas_vld), 32'd0);
        chk_outs("rst_mid", '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        last = '0;

        sb.push_back(mk(1024, 0, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < PER; p++) step(p < 1024, 1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
